// File: rtl/gobou_serial_stream_pkg.sv
// Shared constants and state type for the gobou parallel-to-serial stream.
// Core geometry defaults mirror the existing gobou/ninjin headers.
package gobou_serial_stream_pkg;

  localparam int GOBOU_CORE   = 16;
  localparam int GOBOU_DWIDTH = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/gobou_lane_order.sv
// Reorders the first count_i lanes of a packed vector (forward or reversed)
// and zero-fills every slot at or above count_i.
module gobou_lane_order #(
  parameter int CORE   = 16,
  parameter int DWIDTH = 16,
  parameter int LWIDTH = $clog2(CORE + 1)
) (
  input  logic [CORE*DWIDTH-1:0] data_i,
  input  logic [LWIDTH-1:0]      count_i,
  input  logic                   rev_i,
  output logic [CORE*DWIDTH-1:0] data_o
);

  always_comb begin
    data_o = '0;
    for (int j = 0; j < CORE; j++) begin
      if (j < int'(count_i)) begin
        if (rev_i) begin
          data_o[j*DWIDTH +: DWIDTH] = data_i[(int'(count_i) - 1 - j)*DWIDTH +: DWIDTH];
        end else begin
          data_o[j*DWIDTH +: DWIDTH] = data_i[j*DWIDTH +: DWIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/gobou_serial_stream.sv
// Parallel-to-serial lane shifter: loads one packed vector per handshake and
// emits its lanes one per cycle, reloading on the final beat without a bubble.
module gobou_serial_stream
  import gobou_serial_stream_pkg::*;
#(
  parameter int CORE   = GOBOU_CORE,
  parameter int DWIDTH = GOBOU_DWIDTH,
  parameter int LWIDTH = $clog2(CORE + 1)
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CORE*DWIDTH-1:0]   in_data,
  input  logic [LWIDTH-1:0]        in_count,
  input  logic                     in_rev,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DWIDTH-1:0] out_data,
  output logic                     out_last,
  output logic                     busy
);

  localparam logic [LWIDTH-1:0] CORE_L = LWIDTH'(CORE);
  localparam logic [LWIDTH-1:0] ONE_L  = LWIDTH'(1);

  logic [CORE*DWIDTH-1:0] data_q, data_d, ordered;
  logic [LWIDTH-1:0]      left_q, left_d, eff_count;
  state_e                 state_q;
  logic                   last_q;
  logic                   accept, consume;

  assign eff_count = (in_count > CORE_L) ? CORE_L : in_count;

  gobou_lane_order #(
    .CORE   (CORE),
    .DWIDTH (DWIDTH),
    .LWIDTH (LWIDTH)
  ) u_lane_order (
    .data_i  (in_data),
    .count_i (eff_count),
    .rev_i   (in_rev),
    .data_o  (ordered)
  );

  // Ready while empty, or on the last beat if the sink takes it this cycle.
  assign in_ready = (left_q == '0) || ((left_q == ONE_L) && out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;

  always_comb begin
    data_d = data_q;
    left_d = left_q;
    if (accept) begin
      data_d = ordered;
      left_d = eff_count;
    end else if (consume) begin
      data_d = {{DWIDTH{1'b0}}, data_q[CORE*DWIDTH-1:DWIDTH]};
      left_d = left_q - ONE_L;
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      data_q  <= '0;
      left_q  <= '0;
      state_q <= IDLE;
      last_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      left_q  <= left_d;
      state_q <= (left_d != '0) ? SHIFT : IDLE;
      last_q  <= (left_d == ONE_L);
    end
  end

  assign out_valid = (state_q == SHIFT);
  assign out_data  = data_q[DWIDTH-1:0];
  assign out_last  = last_q;
  assign busy      = out_valid;

endmodule
